// File: rtl/komandara_k10_mem_arbiter.sv
// komandara_k10_mem_arbiter: fetch/LSU arbiter onto one OBI bus, data priority with fetch starvation guard.
module komandara_k10_mem_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            instr_req_i,
  input  logic [AW-1:0]   instr_addr_i,
  output logic            instr_gnt_o,
  output logic            instr_rvalid_o,
  output logic [DW-1:0]   instr_rdata_o,
  output logic            instr_err_o,
  input  logic            data_req_i,
  input  logic            data_we_i,
  input  logic [DW/8-1:0] data_be_i,
  input  logic [AW-1:0]   data_addr_i,
  input  logic [DW-1:0]   data_wdata_i,
  output logic            data_gnt_o,
  output logic            data_rvalid_o,
  output logic [DW-1:0]   data_rdata_o,
  output logic            data_err_o,
  input  logic            flush_i,
  output logic            bus_req_o,
  output logic            bus_we_o,
  output logic [DW/8-1:0] bus_be_o,
  output logic [AW-1:0]   bus_addr_o,
  output logic [DW-1:0]   bus_wdata_o,
  input  logic            bus_gnt_i,
  input  logic            bus_rvalid_i,
  input  logic [DW-1:0]   bus_rdata_i,
  input  logic            bus_err_i,
  output logic            busy_o
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [3:0] LIM  = 4'(STARVE_LIMIT);
  logic [1:0] state;
  logic       owner;
  logic [3:0] starve_cnt;
  logic       kill;
  logic       idle, data_win, sel_data, fire, resp_v;
  always_comb begin
    idle           = state == IDLE;
    data_win       = data_req_i & (~instr_req_i | (starve_cnt < LIM));
    sel_data       = idle ? data_win : owner;
    bus_req_o      = rst_ni & (idle ? (instr_req_i | data_req_i) : state == REQ);
    fire           = bus_req_o & bus_gnt_i;
    bus_we_o       = bus_req_o & sel_data & data_we_i;
    bus_be_o       = bus_req_o ? (sel_data ? data_be_i : '1) : '0;
    bus_addr_o     = bus_req_o ? (sel_data ? data_addr_i : instr_addr_i) : '0;
    bus_wdata_o    = (bus_req_o & sel_data) ? data_wdata_i : '0;
    instr_gnt_o    = fire & ~sel_data;
    data_gnt_o     = fire & sel_data;
    resp_v         = (state == RESP) & bus_rvalid_i;
    data_rvalid_o  = resp_v & owner;
    instr_rvalid_o = resp_v & ~owner & ~kill & ~flush_i;
    instr_rdata_o  = bus_rdata_i;
    data_rdata_o   = bus_rdata_i;
    instr_err_o    = bus_err_i;
    data_err_o     = bus_err_i;
    busy_o         = ~idle;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state      <= IDLE;
      owner      <= 1'b0;
      starve_cnt <= '0;
      kill       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus_req_o) begin
            owner <= data_win;
            state <= bus_gnt_i ? RESP : REQ;
          end
          starve_cnt <= !instr_req_i ? '0 : !fire ? starve_cnt : !data_win ? '0 :
                        (starve_cnt == LIM) ? LIM : starve_cnt + 4'd1;
          kill       <= fire & ~data_win & flush_i;
        end
        REQ: begin
          if (bus_gnt_i) state <= RESP;
          if (flush_i & ~owner) kill <= 1'b1;
        end
        RESP: begin
          if (bus_rvalid_i) begin
            state <= IDLE;
            kill  <= 1'b0;
          end else if (flush_i & ~owner) kill <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_komandara_k10_mem_arbiter.sv
// tb_komandara_k10_mem_arbiter: directed stimulus, transaction-level reference model checked every cycle.
module tb_komandara_k10_mem_arbiter;
  localparam int LIM = 4;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        instr_req = 0, instr_gnt, instr_rvalid, instr_err;
  logic [31:0] instr_addr = 0, instr_rdata;
  logic        data_req = 0, data_we = 0, data_gnt, data_rvalid, data_err;
  logic [3:0]  data_be = 4'hf;
  logic [31:0] data_addr = 0, data_wdata = 0, data_rdata;
  logic        flush = 0;
  logic        bus_req, bus_we, bus_gnt = 0, bus_rvalid = 0, bus_err = 0, busy;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr, bus_wdata, bus_rdata = 0;
  int nvec = 0, nfail = 0;
  bit exp_d [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

  komandara_k10_mem_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(LIM)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_gnt_o(instr_gnt),
    .instr_rvalid_o(instr_rvalid), .instr_rdata_o(instr_rdata), .instr_err_o(instr_err),
    .data_req_i(data_req), .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
    .data_wdata_i(data_wdata), .data_gnt_o(data_gnt), .data_rvalid_o(data_rvalid),
    .data_rdata_o(data_rdata), .data_err_o(data_err), .flush_i(flush),
    .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_be_o(bus_be), .bus_addr_o(bus_addr),
    .bus_wdata_o(bus_wdata), .bus_gnt_i(bus_gnt), .bus_rvalid_i(bus_rvalid),
    .bus_rdata_i(bus_rdata), .bus_err_i(bus_err), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  // Reference model: one transaction at a time, either waiting for its address grant or its response.
  bit m_apend = 0, m_rpend = 0, m_own = 0, m_kill = 0;
  int m_wins = 0;
  always @(negedge clk) begin : model
    bit idle, pick_d, who, req_e, fire, erv_d, erv_i;
    idle   = !m_apend && !m_rpend;
    pick_d = data_req && (!instr_req || m_wins < LIM);
    who    = idle ? pick_d : m_own;
    req_e  = rst_n && (idle ? (instr_req || data_req) : m_apend);
    fire   = req_e && bus_gnt;
    erv_d  = m_rpend && bus_rvalid && m_own;
    erv_i  = m_rpend && bus_rvalid && !m_own && !m_kill && !flush;
    chk("bus_req", bus_req, req_e);
    chk("instr_gnt", instr_gnt, fire && !who);
    chk("data_gnt", data_gnt, fire && who);
    chk("busy", busy, !idle);
    chk("data_rvalid", data_rvalid, erv_d);
    chk("instr_rvalid", instr_rvalid, erv_i);
    if (req_e) begin
      chk("bus_addr", bus_addr, who ? data_addr : instr_addr);
      chk("bus_we", bus_we, who && data_we);
      chk("bus_be", bus_be, who ? data_be : 4'hf);
      if (who && data_we) chk("bus_wdata", bus_wdata, data_wdata);
    end
    if (erv_d) begin
      chk("data_rdata", data_rdata, bus_rdata);
      chk("data_err", data_err, bus_err);
    end
    if (erv_i) begin
      chk("instr_rdata", instr_rdata, bus_rdata);
      chk("instr_err", instr_err, bus_err);
    end
    if (!rst_n) begin
      m_apend <= 0; m_rpend <= 0; m_own <= 0; m_kill <= 0; m_wins <= 0;
    end else if (idle) begin
      if (req_e) begin
        m_own <= pick_d;
        if (bus_gnt) m_rpend <= 1; else m_apend <= 1;
      end
      if (!instr_req) m_wins <= 0;
      else if (fire) m_wins <= pick_d ? ((m_wins + 1 > LIM) ? LIM : m_wins + 1) : 0;
      m_kill <= fire && !pick_d && flush;
    end else if (m_apend) begin
      if (flush && !m_own) m_kill <= 1;
      if (bus_gnt) begin m_apend <= 0; m_rpend <= 1; end
    end else begin
      if (bus_rvalid) begin m_rpend <= 0; m_kill <= 0; end
      else if (flush && !m_own) m_kill <= 1;
    end
  end

  initial begin
    nxt; nxt;
    rst_n = 1;
    @(negedge clk); chk("rst busy", busy, 0); chk("rst req", bus_req, 0);
    nxt;
    // fetch alone
    instr_req = 1; instr_addr = 32'h100; bus_gnt = 1;
    @(negedge clk); chk("fetch gnt", instr_gnt, 1); chk("fetch addr", bus_addr, 32'h100);
    chk("fetch be", bus_be, 4'hf); chk("fetch busy0", busy, 0);
    nxt; instr_req = 0; bus_gnt = 0;
    @(negedge clk); chk("fetch busy1", busy, 1); chk("fetch rv1", instr_rvalid, 0);
    nxt; bus_rvalid = 1; bus_rdata = 32'hDEADBEEF;
    @(negedge clk); chk("fetch rv2", instr_rvalid, 1); chk("fetch rdata", instr_rdata, 32'hDEADBEEF);
    chk("fetch busy2", busy, 1);
    nxt; bus_rvalid = 0; bus_rdata = 0;
    @(negedge clk); chk("fetch busy3", busy, 0);
    nxt;
    // contention: D,D,D,D,I repeating
    instr_req = 1; data_req = 1; instr_addr = 32'h140; data_addr = 32'h400;
    for (int i = 0; i < 10; i++) begin
      bus_gnt = 1;
      @(negedge clk); chk("cont data_gnt", data_gnt, exp_d[i]); chk("cont instr_gnt", instr_gnt, !exp_d[i]);
      nxt; bus_gnt = 0; bus_rvalid = 1;
      nxt; bus_rvalid = 0;
    end
    instr_req = 0; data_req = 0;
    nxt;
    // stall lock: data wins and holds the bus while instr waits
    instr_req = 1; instr_addr = 32'h500; data_req = 1; data_we = 1;
    data_addr = 32'h300; data_wdata = 32'hCAFE0001;
    for (int i = 0; i < 4; i++) begin
      bus_gnt = (i == 3);
      @(negedge clk); chk("stall addr", bus_addr, 32'h300); chk("stall we", bus_we, 1);
      chk("stall instr_gnt", instr_gnt, 0); chk("stall data_gnt", data_gnt, i == 3);
      nxt;
    end
    instr_req = 0; data_req = 0; bus_gnt = 0; bus_rvalid = 1;
    @(negedge clk); chk("stall rvalid", data_rvalid, 1);
    nxt; bus_rvalid = 0; data_we = 0;
    nxt;
    // flush during response phase
    instr_req = 1; instr_addr = 32'h180; bus_gnt = 1;
    nxt; instr_req = 0; bus_gnt = 0; flush = 1;
    nxt; flush = 0; bus_rvalid = 1; bus_rdata = 32'h11111111;
    @(negedge clk); chk("kill rvalid", instr_rvalid, 0);
    nxt; bus_rvalid = 0;
    @(negedge clk); chk("kill busy", busy, 0);
    nxt; instr_req = 1; instr_addr = 32'h200; bus_gnt = 1;
    @(negedge clk); chk("refetch addr", bus_addr, 32'h200); chk("refetch gnt", instr_gnt, 1);
    nxt; instr_req = 0; bus_gnt = 0; bus_rvalid = 1; bus_rdata = 32'h22222222;
    @(negedge clk); chk("refetch rvalid", instr_rvalid, 1); chk("refetch rdata", instr_rdata, 32'h22222222);
    nxt; bus_rvalid = 0;
    nxt;
    // flush during stalled address phase: completes, response dropped
    instr_req = 1; instr_addr = 32'h240; flush = 1;
    nxt;
    nxt; flush = 0; bus_gnt = 1;
    @(negedge clk); chk("reqflush gnt", instr_gnt, 1); chk("reqflush addr", bus_addr, 32'h240);
    nxt; instr_req = 0; bus_gnt = 0; bus_rvalid = 1;
    @(negedge clk); chk("reqflush rvalid", instr_rvalid, 0);
    nxt; bus_rvalid = 0;
    nxt;
    // store with error; flush must not touch it
    data_req = 1; data_we = 1; data_be = 4'b0011; data_addr = 32'h600; data_wdata = 32'h12345678; bus_gnt = 1;
    @(negedge clk); chk("store be", bus_be, 4'b0011); chk("store we", bus_we, 1);
    chk("store wdata", bus_wdata, 32'h12345678);
    nxt; data_req = 0; bus_gnt = 0; bus_rvalid = 1; bus_err = 1; flush = 1;
    @(negedge clk); chk("store rvalid", data_rvalid, 1); chk("store err", data_err, 1);
    chk("store instr_rvalid", instr_rvalid, 0);
    nxt; bus_rvalid = 0; bus_err = 0; flush = 0; data_we = 0; data_be = 4'hf;
    nxt;
    // reset mid-op after four data wins: data must win again afterwards
    instr_req = 1; data_req = 1; instr_addr = 32'h710; data_addr = 32'h700;
    for (int i = 0; i < 4; i++) begin
      bus_gnt = 1;
      @(negedge clk); chk("pre-rst data_gnt", data_gnt, 1);
      nxt; bus_gnt = 0;
      if (i < 3) begin
        bus_rvalid = 1;
        nxt; bus_rvalid = 0;
      end
    end
    rst_n = 0;
    @(negedge clk); chk("rst req forced", bus_req, 0);
    nxt; rst_n = 1; bus_rvalid = 1;
    @(negedge clk); chk("stray instr_rvalid", instr_rvalid, 0); chk("stray data_rvalid", data_rvalid, 0);
    chk("stray busy", busy, 0); chk("post-rst winner", bus_addr, 32'h700);
    nxt; bus_rvalid = 0; bus_gnt = 1;
    @(negedge clk); chk("post-rst data_gnt", data_gnt, 1);
    nxt; instr_req = 0; data_req = 0; bus_gnt = 0; bus_rvalid = 1;
    nxt; bus_rvalid = 0;
    nxt; nxt;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
